// File: rtl/sys_seq.sv
// sys_seq: holds one system instruction until the machine is quiescent,
// issues it for one cycle, then enforces a post-flush dead time.
// Ports: clk, rst (async, active-low); in_vld/in_rdy/in_instr/in_pc/
//   in_extra_para/in_rs from dispatch; pipe_empty, mem_busy, kill;
//   sys_vld/sys_instr/sys_pc/sys_extra_para/csr_rs to the sys stage;
//   sys_resp, clear_pipeline from it; busy, wdog_err status.
// Optional: define SYS_SEQ_WDOG_EN to force issue after WDOG_CYC drain cycles.
`ifndef FETCH_PARA_LEN
`define FETCH_PARA_LEN 8
`endif
`ifndef EXEC_PARA_LEN
`define EXEC_PARA_LEN 2
`endif

module sys_seq #(
  parameter int XLEN      = 32,
  parameter int P         = `FETCH_PARA_LEN - `EXEC_PARA_LEN - 3,
  parameter int FLUSH_CYC = 2,
  parameter int WDOG_CYC  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [P-1:0]    in_extra_para,
  input  logic [XLEN-1:0] in_rs,
  input  logic            pipe_empty,
  input  logic            mem_busy,
  input  logic            kill,
  output logic            sys_vld,
  output logic [XLEN-1:0] sys_instr,
  output logic [XLEN-1:0] sys_pc,
  output logic [P-1:0]    sys_extra_para,
  output logic [XLEN-1:0] csr_rs,
  input  logic            sys_resp,
  input  logic            clear_pipeline,
  output logic            busy,
  output logic            wdog_err
);

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYC - 1);

  if (FLUSH_CYC < 1) begin : g_bad_flush
    $error("FLUSH_CYC must be >= 1");
  end
  if (WDOG_CYC < 1 || WDOG_CYC > 65535) begin : g_bad_wdog
    $error("WDOG_CYC must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_FLUSH
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [P-1:0]    r_extra;
  logic [XLEN-1:0] r_rs;
  logic [FW-1:0]   r_fcnt;
  logic            w_accept;
  logic            w_quiet;
  // Normal completion and "no response" both return to IDLE.
  logic            w_unused_resp;

  assign w_unused_resp = sys_resp;
  assign w_quiet  = pipe_empty & ~mem_busy;
  assign in_rdy   = rst & (r_state == S_IDLE) & ~kill;
  assign w_accept = in_vld & in_rdy;

`ifdef SYS_SEQ_WDOG_EN
  localparam logic [15:0] WCMP = 16'(WDOG_CYC - 1);
  logic [15:0] r_wcnt;
  logic        r_wdog;
  assign wdog_err = r_wdog;
`else
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_pc    <= '0;
      r_extra <= '0;
      r_rs    <= '0;
      r_fcnt  <= '0;
`ifdef SYS_SEQ_WDOG_EN
      r_wcnt  <= '0;
      r_wdog  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_instr <= in_instr;
            r_pc    <= in_pc;
            r_extra <= in_extra_para;
            r_rs    <= in_rs;
            r_state <= S_DRAIN;
`ifdef SYS_SEQ_WDOG_EN
            r_wcnt  <= '0;
`endif
          end
        end
        S_DRAIN: begin
          // A younger-than-redirect instr must never reach the sys stage.
          if (kill) begin
            r_state <= S_IDLE;
          end else if (w_quiet) begin
            r_state <= S_ISSUE;
          end
`ifdef SYS_SEQ_WDOG_EN
          else if (r_wcnt == WCMP) begin
            r_wdog  <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
`endif
        end
        S_ISSUE: begin
          if (clear_pipeline) begin
            r_fcnt  <= FLOAD;
            r_state <= S_FLUSH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sys_vld        = (r_state == S_ISSUE);
  assign busy           = (r_state != S_IDLE);
  assign sys_instr      = r_instr;
  assign sys_pc         = r_pc;
  assign sys_extra_para = r_extra;
  assign csr_rs         = r_rs;

endmodule

// File: tb/tb_sys_seq.sv
// tb_sys_seq: directed test of the system-instruction sequencer.
// Drives after posedge+1, checks one step later within the same cycle.
module tb_sys_seq;

  localparam int XLEN = 32;
  localparam int P    = 3;
`ifdef SYS_SEQ_WDOG_EN
  localparam int WDC   = 4;
  localparam int STALL = 2;
`else
  localparam int WDC   = 255;
  localparam int STALL = 10;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_vld = 1'b0;
  logic            in_rdy;
  logic [XLEN-1:0] in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [P-1:0]    in_extra_para = '0;
  logic [XLEN-1:0] in_rs = '0;
  logic            pipe_empty = 1'b1;
  logic            mem_busy = 1'b0;
  logic            kill = 1'b0;
  logic            sys_vld;
  logic [XLEN-1:0] sys_instr;
  logic [XLEN-1:0] sys_pc;
  logic [P-1:0]    sys_extra_para;
  logic [XLEN-1:0] csr_rs;
  logic            sys_resp = 1'b0;
  logic            clear_pipeline = 1'b0;
  logic            busy;
  logic            wdog_err;

  int n_chk  = 0;
  int n_fail = 0;

  sys_seq #(
    .XLEN(XLEN), .P(P), .FLUSH_CYC(2), .WDOG_CYC(WDC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_extra_para(in_extra_para), .in_rs(in_rs),
    .pipe_empty(pipe_empty), .mem_busy(mem_busy), .kill(kill),
    .sys_vld(sys_vld), .sys_instr(sys_instr), .sys_pc(sys_pc),
    .sys_extra_para(sys_extra_para), .csr_rs(csr_rs),
    .sys_resp(sys_resp), .clear_pipeline(clear_pipeline),
    .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_vld        = 1'b1;
    in_pc         = pc;
    in_instr      = pc ^ 32'h1234_0073;
    in_rs         = ~pc;
    in_extra_para = 3'b001;
  endtask

  // Accept at pc, stall DRAIN for STALL cycles via mem_busy or pipe_empty.
  task automatic stall_run(input logic [31:0] pc, input bit use_mem);
    offer(pc);
    if (use_mem) mem_busy = 1'b1;
    else pipe_empty = 1'b0;
    cyc();
    in_vld = 1'b0;
    for (int i = 0; i < STALL; i++) begin
      #1 chk("t2_hold", {63'd0, sys_vld}, 64'd0);
      cyc();
    end
    mem_busy   = 1'b0;
    pipe_empty = 1'b1;
    #1 chk("t2_lastdrain", {63'd0, sys_vld}, 64'd0);
    cyc();
    sys_resp = 1'b1;
    #1 chk("t2_issue", {63'd0, sys_vld}, 64'd1);
    chk("t2_pc", {32'd0, sys_pc}, {32'd0, pc});
    cyc();
    sys_resp = 1'b0;
    #1 chk("t2_idle", {63'd0, sys_vld}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #12;
    chk("rst_vld", {63'd0, sys_vld}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wdog", {63'd0, wdog_err}, 64'd0);
    cyc();
    rst = 1'b1;
    #1 chk("rst_rdy", {63'd0, in_rdy}, 64'd1);

    // 1: basic issue at t+2
    cyc();
    offer(32'h100);
    #1 chk("t1_rdy", {63'd0, in_rdy}, 64'd1);
    cyc();
    in_vld = 1'b0;
    #1 chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_drain_vld", {63'd0, sys_vld}, 64'd0);
    chk("t1_drain_rdy", {63'd0, in_rdy}, 64'd0);
    cyc();
    sys_resp = 1'b1;
    #1 chk("t1_vld", {63'd0, sys_vld}, 64'd1);
    chk("t1_pc", {32'd0, sys_pc}, 64'h100);
    chk("t1_instr", {32'd0, sys_instr}, 64'h1234_0173);
    chk("t1_rs", {32'd0, csr_rs}, 64'hffff_feff);
    chk("t1_extra", {61'd0, sys_extra_para}, 64'd1);
    cyc();
    sys_resp = 1'b0;
    #1 chk("t1_end_vld", {63'd0, sys_vld}, 64'd0);
    chk("t1_end_rdy", {63'd0, in_rdy}, 64'd1);
    chk("t1_end_busy", {63'd0, busy}, 64'd0);

    // 2: stalls, back-to-back accept on IDLE return
    stall_run(32'h200, 1'b1);
    stall_run(32'h300, 1'b0);
`ifndef SYS_SEQ_WDOG_EN
    chk("t2_nowdog", {63'd0, wdog_err}, 64'd0);
`endif

    // 3: kill in DRAIN beats quiescence
    cyc();
    offer(32'h400);
    mem_busy = 1'b1;
    cyc();
    in_vld   = 1'b0;
    mem_busy = 1'b0;
    kill     = 1'b1;
    #1 chk("t3_drain_rdy", {63'd0, in_rdy}, 64'd0);
    cyc();
    kill = 1'b0;
    #1 chk("t3_idle", {63'd0, busy}, 64'd0);
    chk("t3_rdy", {63'd0, in_rdy}, 64'd1);
    chk("t3_novld", {63'd0, sys_vld}, 64'd0);
    cyc();
    #1 chk("t3_novld2", {63'd0, sys_vld}, 64'd0);
    offer(32'h500);
    kill = 1'b1;
    #1 chk("t3_kill_rdy", {63'd0, in_rdy}, 64'd0);
    cyc();
    in_vld = 1'b0;
    kill   = 1'b0;
    #1 chk("t3_nocap_busy", {63'd0, busy}, 64'd0);
    chk("t3_nocap_pc", {32'd0, sys_pc}, 64'h400);

    // 4: clear_pipeline -> 2 dead cycles
    offer(32'h600);
    cyc();
    in_vld = 1'b0;
    cyc();
    clear_pipeline = 1'b1;
    #1 chk("t4_vld", {63'd0, sys_vld}, 64'd1);
    cyc();
    clear_pipeline = 1'b0;
    offer(32'h700);
    #1 chk("t4_f1_rdy", {63'd0, in_rdy}, 64'd0);
    chk("t4_f1_busy", {63'd0, busy}, 64'd1);
    chk("t4_f1_vld", {63'd0, sys_vld}, 64'd0);
    cyc();
    #1 chk("t4_f2_rdy", {63'd0, in_rdy}, 64'd0);
    cyc();
    #1 chk("t4_rdy", {63'd0, in_rdy}, 64'd1);
    chk("t4_held_pc", {32'd0, sys_pc}, 64'h600);
    cyc();
    in_vld = 1'b0;
    #1 chk("t4_new_busy", {63'd0, busy}, 64'd1);
    chk("t4_new_pc", {32'd0, sys_pc}, 64'h700);
    cyc();
    sys_resp = 1'b1;
    #1 chk("t4_new_vld", {63'd0, sys_vld}, 64'd1);
    cyc();
    sys_resp = 1'b0;

    // 5: async reset in DRAIN and in FLUSH
    offer(32'h800);
    mem_busy = 1'b1;
    cyc();
    in_vld = 1'b0;
    #1 chk("t5_d_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b0;
    #1 chk("t5_d_rbusy", {63'd0, busy}, 64'd0);
    chk("t5_d_rvld", {63'd0, sys_vld}, 64'd0);
    mem_busy = 1'b0;
    cyc();
    rst = 1'b1;
    #1 chk("t5_d_rdy", {63'd0, in_rdy}, 64'd1);
    offer(32'h900);
    cyc();
    in_vld = 1'b0;
    cyc();
    clear_pipeline = 1'b1;
    #1 chk("t5_f_vld", {63'd0, sys_vld}, 64'd1);
    cyc();
    clear_pipeline = 1'b0;
    #1 chk("t5_f_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1 chk("t5_f_rbusy", {63'd0, busy}, 64'd0);
    chk("t5_f_rvld", {63'd0, sys_vld}, 64'd0);
    chk("t5_f_rpc", {32'd0, sys_pc}, 64'h0);
    cyc();
    rst = 1'b1;
    #1 chk("t5_f_rdy", {63'd0, in_rdy}, 64'd1);

`ifdef SYS_SEQ_WDOG_EN
    // 6: forced issue after WDOG_CYC drain cycles, sticky flag
    offer(32'hA00);
    mem_busy = 1'b1;
    cyc();
    in_vld = 1'b0;
    #1 chk("t6_w0", {63'd0, wdog_err}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1 chk("t6_wait_vld", {63'd0, sys_vld}, 64'd0);
      chk("t6_wait_wdog", {63'd0, wdog_err}, 64'd0);
    end
    cyc();
    #1 chk("t6_force_vld", {63'd0, sys_vld}, 64'd1);
    chk("t6_wdog", {63'd0, wdog_err}, 64'd1);
    cyc();
    mem_busy = 1'b0;
    offer(32'hB00);
    cyc();
    in_vld = 1'b0;
    cyc();
    #1 chk("t6_next_vld", {63'd0, sys_vld}, 64'd1);
    chk("t6_sticky", {63'd0, wdog_err}, 64'd1);
    cyc();
    rst = 1'b0;
    #1 chk("t6_clr", {63'd0, wdog_err}, 64'd0);
    cyc();
    rst = 1'b1;
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
